// File: rtl/bit_serial_sub.sv
// Bit-serial subtractor: computes a - b - bin LSB first through one full-subtractor
// cell with a registered borrow, behind ready/valid handshakes on both sides.
module bit_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, diff_nx;
  logic             brw, brw_nx, d, last;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell on the current LSBs; diff_nx shifts the new bit in at the MSB.
  always_comb begin
    d                = sa[0] ^ sb[0] ^ brw;
    brw_nx           = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
    diff_nx          = diff >> 1;
    diff_nx[WIDTH-1] = d;
    last             = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa  <= a;
            sb  <= b;
            brw <= bin;
            cnt <= '0;
          end
        end
        RUN: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          brw  <= brw_nx;
          diff <= diff_nx;
          cnt  <= cnt + CW'(1);
          // brw here is the borrow into the MSB, so its change across the cell is signed overflow
          if (last) begin
            bout <= brw_nx;
            ovf  <= brw ^ brw_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_sub.sv
// Scoreboard bench for bit_serial_sub: an 8-bit and a 1-bit instance, expected results
// from integer arithmetic, checked by independent monitors whenever out_valid is high.
module tb_bit_serial_sub;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv8, ir8, ov8, bin8, bo8, of8;
  logic [W-1:0] a8, b8, d8;
  logic         iv1, ir1, ov1, bin1, bo1, of1;
  logic [0:0]   a1, b1, d1;
  logic         out_ready = 1'b0;

  bit_serial_sub #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(out_ready), .diff(d8), .bout(bo8), .ovf(of8)
  );

  bit_serial_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .bin(bin1),
    .out_valid(ov1), .out_ready(out_ready), .diff(d1), .bout(bo1), .ovf(of1)
  );

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       of;
    int         acc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   force_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model8(logic [7:0] a, logic [7:0] b, logic bi, int acc);
    exp_t e;
    int u, s;
    u = int'(a) - int'(b) - int'(bi);
    s = int'($signed(a)) - int'($signed(b)) - int'(bi);
    e.d = u[7:0];
    e.bo = (u < 0);
    e.of = (s < -128) || (s > 127);
    e.acc = acc;
    return e;
  endfunction

  function automatic exp_t model1(logic [0:0] a, logic [0:0] b, logic bi, int acc);
    exp_t e;
    int u, s;
    u = int'(a) - int'(b) - int'(bi);
    s = int'($signed(a)) - int'($signed(b)) - int'(bi);
    e.d = {7'b0, u[0]};
    e.bo = (u < 0);
    e.of = (s < -1) || (s > 0);
    e.acc = acc;
    return e;
  endfunction

  initial begin : mon8
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) prev = 1'b0;
      else begin
        if (ov8 === 1'b1) begin
          if (q8.size() == 0) chk("spurious_out8", ov8, 0);
          else begin
            if (!prev) chk("latency8", cyc - q8[0].acc, W);
            chk("diff8", d8, q8[0].d);
            chk("bout8", bo8, q8[0].bo);
            chk("ovf8", of8, q8[0].of);
            if (out_ready) void'(q8.pop_front());
          end
        end
        prev = (ov8 === 1'b1);
      end
    end
  end

  initial begin : mon1
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) prev = 1'b0;
      else begin
        if (ov1 === 1'b1) begin
          if (q1.size() == 0) chk("spurious_out1", ov1, 0);
          else begin
            if (!prev) chk("latency1", cyc - q1[0].acc, 1);
            chk("diff1", d1, q1[0].d);
            chk("bout1", bo1, q1[0].bo);
            chk("ovf1", of1, q1[0].of);
            if (out_ready) void'(q1.pop_front());
          end
        end
        prev = (ov1 === 1'b1);
      end
    end
  end

  // Accept is certain at the next edge once in_ready is seen high here, so the
  // expectation (with its accept cycle) is queued before the DUT can respond.
  task automatic send8(logic [7:0] a, logic [7:0] b, logic bi, bit push, int junk);
    int t = 0;
    @(negedge clk);
    while (ir8 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    if (ir8 !== 1'b1) begin chk("in_ready8_timeout", ir8, 1); return; end
    a8 = a; b8 = b; bin8 = bi; iv8 = 1'b1;
    if (push) q8.push_back(model8(a, b, bi, cyc + 1));
    @(negedge clk);
    iv8 = 1'b0;
    for (int i = 0; i < junk; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      iv8 = (ir8 === 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    iv8 = 1'b0;
  endtask

  task automatic send1(logic [0:0] a, logic [0:0] b, logic bi);
    int t = 0;
    @(negedge clk);
    while (ir1 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    if (ir1 !== 1'b1) begin chk("in_ready1_timeout", ir1, 1); return; end
    a1 = a; b1 = b; bin1 = bi; iv1 = 1'b1;
    q1.push_back(model1(a, b, bi, cyc + 1));
    @(negedge clk);
    iv1 = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q8.size() + q1.size()) != 0 && t < 3000) begin @(negedge clk); t++; end
    chk("drain", q8.size() + q1.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    iv1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready8", ir8, 1);
    chk("rst_out_valid8", ov8, 0);
    chk("rst_diff8", d8, 0);
    chk("rst_bout8", bo8, 0);
    chk("rst_ovf8", of8, 0);
    chk("rst_in_ready1", ir1, 1);
    chk("rst_out_valid1", ov1, 0);
    rst = 1'b0;

    send8(8'h05, 8'h03, 1'b0, 1'b1, 0);
    send8(8'h03, 8'h05, 1'b0, 1'b1, 0);
    send8(8'h80, 8'h01, 1'b0, 1'b1, 0);
    send8(8'h00, 8'h00, 1'b1, 1'b1, 6);
    send8(8'h7F, 8'hFF, 1'b0, 1'b1, 3);
    send8(8'hFF, 8'hFF, 1'b1, 1'b1, 0);
    for (int i = 0; i < 40; i++)
      send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, int'($urandom_range(0, 4)));
    wait_drain();

    // Backpressure: result must sit unchanged (monitor checks every cycle) while stalled
    force_stall = 1'b1;
    send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 0);
    t = 0;
    while (ov8 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("stall_reached_done", ov8, 1);
    repeat (5) @(negedge clk);
    chk("stall_valid_held", ov8, 1);
    force_stall = 1'b0;
    wait_drain();

    // Abort mid-RUN: no expectation queued, so any later out_valid is flagged
    send8(8'hA5, 8'h3C, 1'b1, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("midrun_busy", ir8, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready8", ir8, 1);
    chk("abort_out_valid8", ov8, 0);
    chk("abort_diff8", d8, 0);
    chk("abort_bout8", bo8, 0);
    chk("abort_ovf8", of8, 0);
    repeat (15) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      send1(v[2], v[1], v[0]);
    end
    for (int i = 0; i < 12; i++) send1(1'($urandom), 1'($urandom), 1'($urandom));
    send8(8'h05, 8'h03, 1'b0, 1'b1, 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
